// File: rtl/sram_fifo_ctrl.sv
// Byte FIFO controller in front of a single-port asynchronous-read SRAM.
// One SRAM access per cycle, read/write arbitrated round-robin, registered read port.
module sram_fifo_ctrl #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W:0]   level,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_wr,
    output logic              sram_cs,
    input  logic [DATA_W-1:0] sram_dout
);

    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    mem_cnt_q, mem_cnt_d;
    logic                last_gnt_q, last_gnt_d;
    logic                m_valid_q, m_valid_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;

    logic run;
    logic mem_empty;
    logic mem_full;
    logic rd_req;
    logic wr_req;
    logic rd_gnt;
    logic wr_gnt;

    always_comb begin
        run       = (state_q == RUN);
        mem_empty = (mem_cnt_q == '0);
        mem_full  = (mem_cnt_q == CNT_W'(DEPTH));

        // A flush cycle blocks both requests so the SRAM stays idle.
        rd_req = run & !clr & !mem_empty & (!m_valid_q | m_ready);
        wr_req = run & !clr & s_valid & !mem_full;

        // On contention, grant the side that lost last time (last_gnt_q: 1 = write).
        rd_gnt = rd_req & (!wr_req | last_gnt_q);
        wr_gnt = wr_req & (!rd_req | !last_gnt_q);

        s_ready = run & !mem_full & !rd_gnt & !clr;

        sram_cs   = rd_gnt | wr_gnt;
        sram_wr   = wr_gnt;
        sram_addr = wr_gnt ? wr_ptr_q : rd_ptr_q;
        sram_din  = wr_gnt ? s_data : '0;

        m_valid = m_valid_q;
        m_data  = m_data_q;
        level   = mem_cnt_q + CNT_W'(m_valid_q);
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        mem_cnt_d  = mem_cnt_q;
        last_gnt_d = last_gnt_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;

        unique case (state_q)
            INIT: begin
                state_d = RUN;
            end
            RUN: begin
                if (clr) begin
                    wr_ptr_d   = '0;
                    rd_ptr_d   = '0;
                    mem_cnt_d  = '0;
                    last_gnt_d = 1'b0;
                    m_valid_d  = 1'b0;
                    m_data_d   = '0;
                end else begin
                    if (wr_gnt) begin
                        wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
                        mem_cnt_d  = mem_cnt_q + CNT_W'(1);
                        last_gnt_d = 1'b1;
                    end
                    // A read grant reloads the output register even while it is
                    // being consumed, giving one byte per clock when uncontended.
                    if (rd_gnt) begin
                        rd_ptr_d   = rd_ptr_q + ADDR_W'(1);
                        mem_cnt_d  = mem_cnt_q - CNT_W'(1);
                        last_gnt_d = 1'b0;
                        m_valid_d  = 1'b1;
                        m_data_d   = sram_dout;
                    end else if (m_valid_q && m_ready) begin
                        m_valid_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            mem_cnt_q  <= '0;
            last_gnt_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_cnt_q  <= mem_cnt_d;
            last_gnt_q <= last_gnt_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
        end
    end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1K x 8 async-read SRAM
// and a byte scoreboard for FIFO ordering.
module tb_sram_fifo_ctrl;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic [10:0] level;
    logic [9:0]  sram_addr;
    logic [7:0]  sram_din;
    logic        sram_wr;
    logic        sram_cs;
    logic [7:0]  sram_dout;

    logic [7:0]  mem [0:1023];
    logic [7:0]  q[$];
    logic [9:0]  exp_addr;
    int          checks;
    int          errors;

    sram_fifo_ctrl #(.ADDR_W(10), .DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .level     (level),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_wr   (sram_wr),
        .sram_cs   (sram_cs),
        .sram_dout (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (sram_cs && sram_wr) mem[sram_addr] <= sram_din;
    assign sram_dout = (sram_cs && !sram_wr) ? mem[sram_addr] : 8'h00;

    // All tasks start and end 1 time unit after a rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        exp_addr = '0;
        q.delete();
    endtask

    task automatic push(input logic [7:0] d);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        #1;
        while (!s_ready && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (!s_ready) begin
            errors++;
            $display("FAIL push_timeout: s_ready=%0b required 1", s_ready);
        end else begin
            if (sram_cs !== 1'b1 || sram_wr !== 1'b1 || sram_addr !== exp_addr || sram_din !== d) begin
                errors++;
                $display("FAIL push_sram: cs=%0b wr=%0b addr=%0d din=%h required cs=1 wr=1 addr=%0d din=%h",
                         sram_cs, sram_wr, sram_addr, sram_din, exp_addr, d);
            end
            q.push_back(d);
            exp_addr = exp_addr + 10'd1;
        end
        step();
        s_valid = 1'b0;
    endtask

    task automatic pop();
        int n;
        n = 0;
        #1;
        while (!m_valid && n < 2000) begin
            @(posedge clk);
            #2;
            n++;
        end
        checks++;
        if (!m_valid || q.size() == 0) begin
            errors++;
            $display("FAIL pop_timeout: m_valid=%0b queued=%0d required m_valid=1 with data queued", m_valid, q.size());
        end else begin
            if (m_data !== q[0]) begin
                errors++;
                $display("FAIL pop_data: m_data=%h required %h", m_data, q[0]);
            end
            void'(q.pop_front());
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 1100) begin
            pop();
            n++;
        end
        checks++;
        if (level !== 11'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain_empty: level=%0d m_valid=%0b required 0 0", level, m_valid);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; s_valid = 1'b1; s_data = 8'h99; m_ready = 1'b0;
        exp_addr = '0;
        #3;
        checks++;
        if (sram_cs !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || level !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: cs=%0b s_ready=%0b m_valid=%0b level=%0d required 0 0 0 0",
                     sram_cs, s_ready, m_valid, level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checks++;
        if (s_ready !== 1'b0 || sram_cs !== 1'b0) begin
            errors++;
            $display("FAIL init_idle: s_ready=%0b cs=%0b required 0 0", s_ready, sram_cs);
        end
        step();
        checks++;
        if (s_ready !== 1'b1 || level !== 11'd0) begin
            errors++;
            $display("FAIL run_entry: s_ready=%0b level=%0d required 1 0", s_ready, level);
        end
        s_valid = 1'b0;
    endtask

    task automatic test_basic();
        m_ready = 1'b0;
        push(8'hFC);
        push(8'h3C);
        push(8'hA5);
        #1;
        checks++;
        if (level !== 11'd3 || m_valid !== 1'b1 || m_data !== 8'hFC) begin
            errors++;
            $display("FAIL basic_prefetch: level=%0d m_valid=%0b m_data=%h required 3 1 fc", level, m_valid, m_data);
        end
        pop();
        pop();
        pop();
        checks++;
        if (level !== 11'd0) begin
            errors++;
            $display("FAIL basic_level: level=%0d required 0", level);
        end
    endtask

    task automatic test_fill();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 1025; i++) push(8'(i) ^ 8'h5A);
        #1;
        checks++;
        if (level !== 11'd1025 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d s_ready=%0b required 1025 0", level, s_ready);
        end
        s_valid = 1'b1;
        s_data  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++;
            if (s_ready !== 1'b0 || sram_cs !== 1'b0 || level !== 11'd1025) begin
                errors++;
                $display("FAIL full_hold: s_ready=%0b cs=%0b level=%0d required 0 0 1025", s_ready, sram_cs, level);
            end
        end
        step();
        pop();
        checks++;
        if (level !== 11'd1024) begin
            errors++;
            $display("FAIL full_pop_level: level=%0d required 1024", level);
        end
        push(8'hEE);
        drain();
    endtask

    task automatic test_contention();
        logic [7:0] nxt;
        logic       prev_wr;
        do_reset();
        m_ready = 1'b0;
        push(8'h01);
        push(8'h02);
        nxt = 8'h03;
        prev_wr = 1'b1;
        s_valid = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            s_data = nxt;
            #1;
            checks++;
            if (sram_cs !== 1'b1 || sram_wr === prev_wr) begin
                errors++;
                $display("FAIL contention_grant: cycle=%0d cs=%0b wr=%0b prev_wr=%0b required cs=1 alternating",
                         i, sram_cs, sram_wr, prev_wr);
            end
            prev_wr = sram_wr;
            if (m_valid) begin
                checks++;
                if (q.size() == 0 || m_data !== q[0]) begin
                    errors++;
                    $display("FAIL contention_data: m_data=%h queued=%0d", m_data, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            if (s_ready) begin
                q.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        drain();
    endtask

    task automatic test_clr();
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
        #1;
        checks++;
        if (level !== 11'd5) begin
            errors++;
            $display("FAIL clr_setup_level: level=%0d required 5", level);
        end
        clr = 1'b1;
        s_valid = 1'b1;
        s_data = 8'h77;
        #1;
        checks++;
        if (s_ready !== 1'b0 || sram_cs !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle: s_ready=%0b cs=%0b required 0 0", s_ready, sram_cs);
        end
        step();
        clr = 1'b0;
        s_valid = 1'b0;
        #1;
        checks++;
        if (level !== 11'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_flush: level=%0d m_valid=%0b required 0 0", level, m_valid);
        end
        q.delete();
        exp_addr = '0;
        push(8'h11);
        #1;
        checks++;
        if (m_valid !== 1'b0 || sram_cs !== 1'b1 || sram_wr !== 1'b0 || sram_addr !== 10'd0) begin
            errors++;
            $display("FAIL clr_read_addr: m_valid=%0b cs=%0b wr=%0b addr=%0d required 0 1 0 0",
                     m_valid, sram_cs, sram_wr, sram_addr);
        end
        step();
        pop();
    endtask

    task automatic test_back_pressure();
        logic       hold;
        logic [7:0] held;
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'hC0 ^ 8'(i * 7));
        hold = 1'b0;
        held = '0;
        for (int i = 0; i < 60; i++) begin
            m_ready = 1'($urandom_range(0, 1));
            #1;
            if (hold) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    errors++;
                    $display("FAIL bp_stable: m_valid=%0b m_data=%h required 1 %h", m_valid, m_data, held);
                end
            end
            if (m_valid && m_ready) begin
                checks++;
                if (q.size() == 0 || m_data !== q[0]) begin
                    errors++;
                    $display("FAIL bp_data: m_data=%h queued=%0d", m_data, q.size());
                end
                if (q.size() != 0) void'(q.pop_front());
            end
            hold = m_valid && !m_ready;
            held = m_data;
            step();
        end
        m_ready = 1'b0;
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        m_ready = 1'b0;
        push(8'h41);
        push(8'h42);
        s_valid = 1'b1;
        s_data = 8'h43;
        #1;
        checks++;
        if (sram_cs !== 1'b1 || level !== 11'd2) begin
            errors++;
            $display("FAIL async_setup: cs=%0b level=%0d required 1 2", sram_cs, level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (sram_cs !== 1'b0 || sram_wr !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b0 || level !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: cs=%0b wr=%0b s_ready=%0b m_valid=%0b level=%0d required 0 0 0 0 0",
                     sram_cs, sram_wr, s_ready, m_valid, level);
        end
        s_valid = 1'b0;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_fill();
        test_contention();
        test_clr();
        test_back_pressure();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
